spi_txn_queue: RTL and testbench

SPI_TXN_QUEUE -- requirements
Module: spi_txn_queue

---
 rtl/spi_txn_queue_if.sv | 45 ++++
 rtl/spi_txn_queue.sv | 172 +++++++++++++++++
 tb/tb_spi_txn_queue.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_txn_queue_if.sv
// rtl/spi_txn_queue_if.sv - Host, SPI driver and response signal bundle for spi_txn_queue
//
// Purpose: carries the host command stream, the downstream SPI driver handshake
// and the host response stream as one bundle.
// Ports (by group):
//   command  : cmd_valid, cmd_ready, cmd_nclks, cmd_data, cmd_err
//   driver   : drv_start, drv_rdy, drv_nclks, drv_tx_data, drv_done, drv_rx_data
//   response : rsp_valid, rsp_ready, rsp_data
//   status   : busy
// Modports: slave = the queue itself, master = the host/driver environment.

interface spi_txn_queue_if #(
  parameter int SPI_MAXLEN = 16
);
  localparam int NW = $clog2(SPI_MAXLEN) + 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [NW-1:0]         cmd_nclks;
  logic [SPI_MAXLEN-1:0] cmd_data;
  logic                  cmd_err;

  logic                  drv_start;
  logic                  drv_rdy;
  logic [NW-1:0]         drv_nclks;
  logic [SPI_MAXLEN-1:0] drv_tx_data;
  logic                  drv_done;
  logic [SPI_MAXLEN-1:0] drv_rx_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [SPI_MAXLEN-1:0] rsp_data;

  logic                  busy;

  modport slave (
    input  cmd_valid, cmd_nclks, cmd_data, drv_rdy, drv_done, drv_rx_data, rsp_ready,
    output cmd_ready, cmd_err, drv_start, drv_nclks, drv_tx_data, rsp_valid, rsp_data, busy
  );

  modport master (
    output cmd_valid, cmd_nclks, cmd_data, drv_rdy, drv_done, drv_rx_data, rsp_ready,
    input  cmd_ready, cmd_err, drv_start, drv_nclks, drv_tx_data, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/spi_txn_queue.sv
// rtl/spi_txn_queue.sv - Command/response queue sequencing transactions to an SPI driver
//
// Purpose: buffers host SPI commands in a DEPTH-entry FIFO, issues them one at a
// time to a downstream SPI driver, and returns the masked MISO data in command
// order through a DEPTH-entry response FIFO.
// Ports:
//   SCLK    : clock, rising edge
//   sresetn : synchronous active-low reset
//   bus     : spi_txn_queue_if.slave (command, driver, response and busy signals)

module spi_txn_queue #(
  parameter int SPI_MAXLEN = 16,
  parameter int DEPTH      = 4
) (
  input  logic           SCLK,
  input  logic           sresetn,
  spi_txn_queue_if.slave bus
);
  localparam int NW = $clog2(SPI_MAXLEN) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [NW-1:0] MAXLEN_N = NW'(SPI_MAXLEN);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [NW-1:0]         r_cmd_nclks_mem [DEPTH];
  logic [SPI_MAXLEN-1:0] r_cmd_data_mem  [DEPTH];
  logic [AW-1:0]         r_cmd_wr_ptr;
  logic [AW-1:0]         r_cmd_rd_ptr;
  logic [CW-1:0]         r_cmd_count;

  logic [SPI_MAXLEN-1:0] r_rsp_mem [DEPTH];
  logic [AW-1:0]         r_rsp_wr_ptr;
  logic [AW-1:0]         r_rsp_rd_ptr;
  logic [CW-1:0]         r_rsp_count;

  logic [NW-1:0]         r_drv_nclks;
  logic [SPI_MAXLEN-1:0] r_drv_tx_data;
  logic [SPI_MAXLEN-1:0] r_rx_data;
  logic                  r_cmd_err;

  logic                  w_len_legal;
  logic                  w_cmd_push;
  logic                  w_cmd_pop;
  logic                  w_rsp_push;
  logic                  w_rsp_pop;
  logic                  w_rsp_valid;
  logic                  w_drv_start;
  logic                  w_rx_capture;
  logic                  w_in_flight;
  logic [CW-1:0]         w_rsp_reserved;
  logic                  w_rsp_slot_free;
  logic [SPI_MAXLEN-1:0] w_rx_mask;

  assign bus.cmd_ready = (r_cmd_count != DEPTH_C);
  assign w_len_legal   = (bus.cmd_nclks != '0) && (bus.cmd_nclks <= MAXLEN_N);
  assign w_cmd_push    = bus.cmd_valid && bus.cmd_ready && w_len_legal;

  assign w_rsp_valid   = (r_rsp_count != '0);
  assign w_rsp_pop     = w_rsp_valid && bus.rsp_ready;

  // Any non-IDLE state owns one response slot, so issuing only when
  // count + in-flight has room means STORE can never hit a full FIFO.
  assign w_in_flight     = (r_state != S_IDLE);
  assign w_rsp_reserved  = r_rsp_count + CW'(w_in_flight);
  assign w_rsp_slot_free = (w_rsp_reserved < DEPTH_C);

  // MISO bits beyond the transaction length are undefined on the wire.
  always_comb begin
    w_rx_mask = '0;
    for (int i = 0; i < SPI_MAXLEN; i++) begin
      w_rx_mask[i] = (NW'(i) < r_drv_nclks);
    end
  end

  always_ff @(posedge SCLK) begin
    if (!sresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_drv_start  = 1'b0;
    w_cmd_pop    = 1'b0;
    w_rx_capture = 1'b0;
    w_rsp_push   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_cmd_count != '0) && w_rsp_slot_free) begin
          w_cmd_pop   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.drv_rdy) begin
          w_drv_start = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.drv_done) begin
          w_rx_capture = 1'b1;
          w_state_nxt  = S_STORE;
        end
      end
      S_STORE: begin
        w_rsp_push  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (!sresetn) begin
      r_cmd_wr_ptr  <= '0;
      r_cmd_rd_ptr  <= '0;
      r_cmd_count   <= '0;
      r_rsp_wr_ptr  <= '0;
      r_rsp_rd_ptr  <= '0;
      r_rsp_count   <= '0;
      r_drv_nclks   <= '0;
      r_drv_tx_data <= '0;
      r_rx_data     <= '0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_cmd_err <= bus.cmd_valid && bus.cmd_ready && !w_len_legal;

      if (w_cmd_push) r_cmd_wr_ptr <= r_cmd_wr_ptr + 1'b1;
      if (w_cmd_pop) begin
        r_cmd_rd_ptr  <= r_cmd_rd_ptr + 1'b1;
        r_drv_nclks   <= r_cmd_nclks_mem[r_cmd_rd_ptr];
        r_drv_tx_data <= r_cmd_data_mem[r_cmd_rd_ptr];
      end
      if (w_cmd_push && !w_cmd_pop)      r_cmd_count <= r_cmd_count + 1'b1;
      else if (!w_cmd_push && w_cmd_pop) r_cmd_count <= r_cmd_count - 1'b1;

      if (w_rx_capture) r_rx_data <= bus.drv_rx_data & w_rx_mask;

      if (w_rsp_push) r_rsp_wr_ptr <= r_rsp_wr_ptr + 1'b1;
      if (w_rsp_pop)  r_rsp_rd_ptr <= r_rsp_rd_ptr + 1'b1;
      if (w_rsp_push && !w_rsp_pop)      r_rsp_count <= r_rsp_count + 1'b1;
      else if (!w_rsp_push && w_rsp_pop) r_rsp_count <= r_rsp_count - 1'b1;
    end
  end

  // Storage arrays carry no reset; the pointers and counts define validity.
  always_ff @(posedge SCLK) begin
    if (w_cmd_push) begin
      r_cmd_nclks_mem[r_cmd_wr_ptr] <= bus.cmd_nclks;
      r_cmd_data_mem[r_cmd_wr_ptr]  <= bus.cmd_data;
    end
    if (w_rsp_push) begin
      r_rsp_mem[r_rsp_wr_ptr] <= r_rx_data;
    end
  end

  assign bus.cmd_err     = r_cmd_err;
  assign bus.drv_start   = w_drv_start;
  assign bus.drv_nclks   = r_drv_nclks;
  assign bus.drv_tx_data = r_drv_tx_data;
  assign bus.rsp_valid   = w_rsp_valid;
  assign bus.rsp_data    = w_rsp_valid ? r_rsp_mem[r_rsp_rd_ptr] : '0;
  assign bus.busy        = (r_state != S_IDLE) || (r_cmd_count != '0);
endmodule

// File: tb/tb_spi_txn_queue.sv
// tb/tb_spi_txn_queue.sv - Scoreboard testbench for spi_txn_queue
module tb_spi_txn_queue;
  localparam int ML = 16;
  localparam int DP = 4;

  logic SCLK = 1'b0;
  logic sresetn;
  always #5 SCLK = ~SCLK;

  spi_txn_queue_if #(.SPI_MAXLEN(ML)) bus ();

  spi_txn_queue #(.SPI_MAXLEN(ML), .DEPTH(DP)) dut (
    .SCLK    (SCLK),
    .sresetn (sresetn),
    .bus     (bus)
  );

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_start = 0;
  int n_rsp   = 0;
  int drv_lat = 4;
  int drv_cnt = 0;

  logic          drv_done_r = 1'b0;
  logic [ML-1:0] drv_rx_r   = '0;
  logic [ML-1:0] drv_cur_rx = '0;
  assign bus.drv_done    = drv_done_r;
  assign bus.drv_rx_data = drv_rx_r;

  logic [4:0]    cmd_q_n [$];
  logic [ML-1:0] cmd_q_d [$];
  logic [ML-1:0] rx_q    [$];
  logic [ML-1:0] exp_q   [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ML-1:0] mask_of(input int n);
    logic [31:0] m;
    m = (n >= ML) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    return m[ML-1:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge SCLK);
    #1;
  endtask

  // Driver model: answers each drv_start with a drv_done after drv_lat cycles.
  always @(negedge SCLK) begin
    drv_done_r = 1'b0;
    if (drv_cnt > 0) begin
      drv_cnt--;
      if (drv_cnt == 0) drv_done_r = 1'b1;
    end
    drv_rx_r = drv_done_r ? drv_cur_rx : 16'hBEEF;
    if (bus.drv_start === 1'b1) begin
      n_start++;
      check("start has queued cmd", cmd_q_n.size() != 0, 1'b1);
      if (cmd_q_n.size() != 0) begin
        check("drv_nclks", bus.drv_nclks, cmd_q_n.pop_front());
        check("drv_tx_data", bus.drv_tx_data, cmd_q_d.pop_front());
        drv_cur_rx = rx_q.pop_front();
      end
      drv_cnt = drv_lat;
    end
  end

  // Response monitor: every handshake pops the scoreboard.
  always @(negedge SCLK) begin
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      n_rsp++;
      check("rsp has expectation", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("rsp_data", bus.rsp_data, exp_q.pop_front());
    end
  end

  task automatic offer(input logic [4:0] n, input logic [ML-1:0] d, input logic [ML-1:0] rx,
                       input logic exp_ready, input logic exp_err);
    check("cmd_ready before offer", bus.cmd_ready, exp_ready);
    bus.cmd_valid = 1'b1;
    bus.cmd_nclks = n;
    bus.cmd_data  = d;
    if (exp_ready && !exp_err) begin
      cmd_q_n.push_back(n);
      cmd_q_d.push_back(d);
      rx_q.push_back(rx);
      exp_q.push_back(rx & mask_of(int'(n)));
    end
    tick(1);
    bus.cmd_valid = 1'b0;
    check("cmd_err after offer", bus.cmd_err, exp_err);
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int b;
    b = budget;
    while (n_rsp < target && b > 0) begin
      tick(1);
      b--;
    end
    check("response count", n_rsp, target);
  endtask

  task automatic wait_valid(input int budget);
    int b;
    b = budget;
    while (bus.rsp_valid !== 1'b1 && b > 0) begin
      tick(1);
      b--;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " cmd_ready"},   bus.cmd_ready,   1'b1);
    check({tag, " cmd_err"},     bus.cmd_err,     1'b0);
    check({tag, " drv_start"},   bus.drv_start,   1'b0);
    check({tag, " drv_nclks"},   bus.drv_nclks,   5'd0);
    check({tag, " drv_tx_data"}, bus.drv_tx_data, 16'h0000);
    check({tag, " rsp_valid"},   bus.rsp_valid,   1'b0);
    check({tag, " rsp_data"},    bus.rsp_data,    16'h0000);
    check({tag, " busy"},        bus.busy,        1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    sresetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_nclks = '0;
    bus.cmd_data  = '0;
    bus.drv_rdy   = 1'b1;
    bus.rsp_ready = 1'b1;
    tick(3);
    check_reset("reset");
    sresetn = 1'b1;
    tick(1);

    // Single transaction, response held so the head can be inspected.
    bus.rsp_ready = 1'b0;
    drv_lat = 8;
    offer(5'd8, 16'h00A5, 16'hFF3C, 1'b1, 1'b0);
    wait_valid(40);
    check("single rsp_valid", bus.rsp_valid, 1'b1);
    check("single rsp_data", bus.rsp_data, 16'h003C);
    check("single start count", n_start, 1);
    bus.rsp_ready = 1'b1;
    wait_rsp(1, 5);
    tick(1);
    check("idle rsp_valid", bus.rsp_valid, 1'b0);
    check("idle busy", bus.busy, 1'b0);

    // Fill the command FIFO behind a stalled driver; overflow offer ignored.
    bus.drv_rdy = 1'b0;
    drv_lat = 3;
    offer(5'd16, 16'hC3A5, 16'h5A5A, 1'b1, 1'b0);
    offer(5'd1,  16'h0001, 16'hFFFF, 1'b1, 1'b0);
    offer(5'd5,  16'h001F, 16'h12F3, 1'b1, 1'b0);
    offer(5'd12, 16'h0ABC, 16'hF00D, 1'b1, 1'b0);
    offer(5'd3,  16'h0005, 16'h0006, 1'b1, 1'b0);
    offer(5'd7,  16'h0077, 16'h00FF, 1'b0, 1'b0);
    check("full cmd_ready", bus.cmd_ready, 1'b0);
    check("stalled busy", bus.busy, 1'b1);
    check("issue regs nclks", bus.drv_nclks, 5'd16);
    check("issue regs data", bus.drv_tx_data, 16'hC3A5);
    tick(4);
    check("no start while drv_rdy low", bus.drv_start, 1'b0);
    check("no start count", n_start, 1);
    bus.drv_rdy = 1'b1;
    #1;
    check("start on drv_rdy", bus.drv_start, 1'b1);
    wait_rsp(6, 80);
    tick(2);
    check("drained busy", bus.busy, 1'b0);

    // Illegal lengths.
    offer(5'd0, 16'h1234, 16'h0000, 1'b1, 1'b1);
    tick(1);
    check("err pulse ends (0)", bus.cmd_err, 1'b0);
    offer(5'd17, 16'h4321, 16'h0000, 1'b1, 1'b1);
    tick(1);
    check("err pulse ends (17)", bus.cmd_err, 1'b0);
    check("illegal busy", bus.busy, 1'b0);
    check("illegal rsp_valid", bus.rsp_valid, 1'b0);
    tick(5);
    check("illegal no start", n_start, 6);

    // Response back-pressure: only DEPTH transactions may complete.
    bus.rsp_ready = 1'b0;
    drv_lat = 2;
    offer(5'd4,  16'h000F, 16'hABCD, 1'b1, 1'b0);
    offer(5'd9,  16'h01FF, 16'h7777, 1'b1, 1'b0);
    offer(5'd16, 16'hFFFF, 16'h8001, 1'b1, 1'b0);
    offer(5'd2,  16'h0002, 16'h0003, 1'b1, 1'b0);
    offer(5'd11, 16'h0555, 16'hFACE, 1'b1, 1'b0);
    tick(60);
    check("backpressure starts", n_start, 10);
    check("backpressure rsp_valid", bus.rsp_valid, 1'b1);
    check("backpressure busy", bus.busy, 1'b1);
    check("backpressure no rsp", n_rsp, 6);
    bus.rsp_ready = 1'b1;
    wait_rsp(11, 80);
    check("backpressure fifth start", n_start, 11);
    tick(2);
    check("scoreboard drained", exp_q.size(), 0);

    // Reset while a transaction is in WAIT with two commands queued.
    drv_lat = 20;
    offer(5'd8, 16'h00AA, 16'h1111, 1'b1, 1'b0);
    offer(5'd8, 16'h00BB, 16'h2222, 1'b1, 1'b0);
    offer(5'd8, 16'h00CC, 16'h3333, 1'b1, 1'b0);
    tick(2);
    check("pre-reset start count", n_start, 12);
    check("pre-reset busy", bus.busy, 1'b1);
    sresetn = 1'b0;
    tick(1);
    check_reset("reset in WAIT");
    sresetn = 1'b1;
    cmd_q_n.delete();
    cmd_q_d.delete();
    rx_q.delete();
    exp_q.delete();
    tick(30);
    check("post-reset no response", n_rsp, 11);
    check("post-reset no start", n_start, 12);
    check("post-reset rsp_valid", bus.rsp_valid, 1'b0);
    check("post-reset busy", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
